// File: rtl/membus_pkg.sv
// Shared constants and helpers for mem_bus_arbiter: I/O region decode,
// I/O select width and the one-hot-to-index conversion.
package membus_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned IO_SEL_W    = 3;
  localparam logic [1:0]  IO_REGION   = 2'b11;

  function automatic int unsigned io_hi_bit(input int unsigned ram_aw);
    return ram_aw;
  endfunction

  function automatic int unsigned io_lo_bit(input int unsigned ram_aw);
    return ram_aw - 1;
  endfunction

  // The two bits just above/at the top of the RAM window select the I/O port.
  function automatic logic is_io_addr(input logic [31:0] addr, input int unsigned ram_aw);
    logic [31:0] shifted;
    shifted = addr >> io_lo_bit(ram_aw);
    return shifted[1:0] == IO_REGION;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: search starts one past last_in and
// wraps; last_out is the winner index, or last_in when nobody is eligible.
module rr_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     elig_in,
  input  logic [IDX_W-1:0] last_in,
  output logic [N-1:0]     gnt_out,
  output logic [IDX_W-1:0] last_out
);

  int unsigned idx;
  logic        hit;

  always_comb begin
    gnt_out = '0;
    hit     = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!hit) begin
        idx = 32'(last_in) + k;
        if (idx >= N) idx = idx - N;
        if ((elig_in & (N'(1) << idx)) != '0) begin
          hit     = 1'b1;
          gnt_out = N'(1) << idx;
        end
      end
    end
    last_out = hit ? onehot_to_idx(MAX_MASTERS'(gnt_out)) : last_in;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master byte bus arbiter/decoder for the shared RAM and HCI I/O port.
// Define MEMBUS_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module mem_bus_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned LOCK_MASTER    = NUM_MASTERS - 1
) (
  input  logic                      clk_in,
  input  logic                      rstn_in,
  input  logic                      lock_in,
  input  logic [NUM_MASTERS-1:0]    m_req_in,
  input  logic [32*NUM_MASTERS-1:0] m_a_in,
  input  logic [NUM_MASTERS-1:0]    m_wr_in,
  input  logic [8*NUM_MASTERS-1:0]  m_dout_in,
  output logic [NUM_MASTERS-1:0]    m_gnt_out,
  output logic [NUM_MASTERS-1:0]    m_rvalid_out,
  output logic [7:0]                m_rdata_out,
  output logic                      ram_en_out,
  output logic                      ram_r_nw_out,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]                ram_d_out,
  input  logic [7:0]                ram_d_in,
  output logic                      io_en_out,
  output logic [IO_SEL_W-1:0]       io_sel_out,
  output logic                      io_wr_out,
  output logic [7:0]                io_d_out,
  input  logic [7:0]                io_d_in,
  input  logic                      io_full_in
);

  logic [NUM_MASTERS-1:0] elig;
  logic [IDX_W-1:0]       last_gnt;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_gnt;
  logic                   sel_io;
  logic                   sel_wr;
  logic [31:0]            sel_a;
  logic [7:0]             sel_d;

  logic                   q_valid_q, q_valid_d;
  logic                   q_io_q, q_io_d;
  logic [IDX_W-1:0]       q_master_q, q_master_d;

  // I/O writes stall while the HCI buffer is full; everything else is unaffected.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_req_in[i]
             && (!lock_in || i == LOCK_MASTER)
             && !(is_io_addr(m_a_in[32*i +: 32], RAM_ADDR_WIDTH) && m_wr_in[i] && io_full_in);
    end
  end

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .elig_in  (elig),
    .last_in  (last_gnt),
    .gnt_out  (m_gnt_out),
    .last_out (win_idx)
  );

`ifdef MEMBUS_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;

  always_comb begin
    last_gnt_d = any_gnt ? win_idx : last_gnt_q;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) last_gnt_q <= IDX_W'(NUM_MASTERS - 1);
    else          last_gnt_q <= last_gnt_d;
  end

  assign last_gnt = last_gnt_q;
`else
  // A pointer pinned at the top index makes the rotating search a fixed priority.
  assign last_gnt = IDX_W'(NUM_MASTERS - 1);
`endif

  always_comb begin
    sel_a  = '0;
    sel_d  = '0;
    sel_wr = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (m_gnt_out[i]) begin
        sel_a  = m_a_in[32*i +: 32];
        sel_d  = m_dout_in[8*i +: 8];
        sel_wr = m_wr_in[i];
      end
    end
    any_gnt      = |m_gnt_out;
    sel_io       = any_gnt && is_io_addr(sel_a, RAM_ADDR_WIDTH);
    ram_en_out   = any_gnt && !sel_io;
    ram_r_nw_out = ram_en_out && !sel_wr;
    ram_a_out    = sel_a[RAM_ADDR_WIDTH-1:0];
    ram_d_out    = sel_d;
    io_en_out    = sel_io;
    io_sel_out   = sel_a[IO_SEL_W-1:0];
    io_wr_out    = sel_io && sel_wr;
    io_d_out     = sel_d;
    q_valid_d    = any_gnt && !sel_wr;
    q_io_d       = sel_io;
    q_master_d   = any_gnt ? win_idx : '0;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      q_valid_q  <= 1'b0;
      q_io_q     <= 1'b0;
      q_master_q <= '0;
    end else begin
      q_valid_q  <= q_valid_d;
      q_io_q     <= q_io_d;
      q_master_q <= q_master_d;
    end
  end

  always_comb begin
    m_rvalid_out = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid_out[i] = q_valid_q && (q_master_q == IDX_W'(i));
    end
    m_rdata_out = q_io_q ? io_d_in : ram_d_in;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver predicts from a behavioural
// model, a negedge monitor compares strobes and read responses.
module tb_mem_bus_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 17;
  localparam int unsigned LM = 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            lock = 1'b0;
  logic            io_full = 1'b0;
  logic [NM-1:0]   req = '0, wr = '0, gnt, rvalid;
  logic [32*NM-1:0] addr = '0;
  logic [8*NM-1:0] dout = '0;
  logic [7:0]      rdata, ram_dq, io_dq;
  logic [7:0]      ram_di = 8'h00, io_di = 8'h00, ram_nx, io_nx;
  logic            ram_en, ram_r_nw, io_en, io_wr;
  logic [AW-1:0]   ram_a;
  logic [2:0]      io_sel;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    bit          act;
    bit          wr;
    logic [31:0] a;
    logic [7:0]  d;
  } txn_t;

  typedef struct packed {
    int          cyc;
    logic [NM-1:0] gnt;
    logic        ram_en, r_nw, io_en, io_wr;
    logic [AW-1:0] ram_a;
    logic [7:0]  ram_d, io_d;
    logic [2:0]  io_sel;
  } rec_t;

  typedef struct packed {
    int         cyc;
    int         m;
    logic [7:0] d;
  } rsp_t;

  txn_t mst[NM];
  rec_t rec_q[$];
  rsp_t rsp_q[$];
  int   mdl_last = NM - 1;
  logic [7:0] mdl_ram[int], mdl_io[int], dev_ram[int], dev_io[int];

  mem_bus_arbiter #(.NUM_MASTERS(NM), .RAM_ADDR_WIDTH(AW), .LOCK_MASTER(LM)) dut (
    .clk_in(clk), .rstn_in(rstn), .lock_in(lock),
    .m_req_in(req), .m_a_in(addr), .m_wr_in(wr), .m_dout_in(dout),
    .m_gnt_out(gnt), .m_rvalid_out(rvalid), .m_rdata_out(rdata),
    .ram_en_out(ram_en), .ram_r_nw_out(ram_r_nw), .ram_a_out(ram_a),
    .ram_d_out(ram_dq), .ram_d_in(ram_di),
    .io_en_out(io_en), .io_sel_out(io_sel), .io_wr_out(io_wr),
    .io_d_out(io_dq), .io_d_in(io_di), .io_full_in(io_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(int key, bit io);
    return 8'((key * 37) ^ (io ? 8'hC3 : 8'h5C));
  endfunction

  function automatic bit is_io(logic [31:0] a);
    return ((a >> (AW - 1)) & 32'h3) == 32'h3;
  endfunction

  function automatic int ram_key(logic [31:0] a);
    return int'(a & ((32'h1 << AW) - 1));
  endfunction

  function automatic logic [7:0] mdl_rd(logic [31:0] a);
    int k;
    if (is_io(a)) begin
      k = int'(a & 32'h7);
      return mdl_io.exists(k) ? mdl_io[k] : init_val(k, 1'b1);
    end
    k = ram_key(a);
    return mdl_ram.exists(k) ? mdl_ram[k] : init_val(k, 1'b0);
  endfunction

  // Behavioural RAM and I/O devices: one-cycle read latency, noise otherwise.
  always @(negedge clk) begin
    if (ram_en && !ram_r_nw) dev_ram[int'(ram_a)] = ram_dq;
    if (io_en && io_wr) dev_io[int'(io_sel)] = io_dq;
    if (ram_en && ram_r_nw)
      ram_nx = dev_ram.exists(int'(ram_a)) ? dev_ram[int'(ram_a)] : init_val(int'(ram_a), 1'b0);
    else
      ram_nx = 8'($urandom);
    if (io_en && !io_wr)
      io_nx = dev_io.exists(int'(io_sel)) ? dev_io[int'(io_sel)] : init_val(int'(io_sel), 1'b1);
    else
      io_nx = 8'($urandom);
  end

  always @(posedge clk) begin
    ram_di <= ram_nx;
    io_di  <= io_nx;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (rec_q.size() != 0) begin
      r = rec_q.pop_front();
      chk("gnt", 64'(gnt), 64'(r.gnt));
      chk("en", {ram_en, io_en, io_wr}, {r.ram_en, r.io_en, r.io_wr});
      if (r.ram_en) chk("ram_bus", {ram_r_nw, ram_a, ram_dq}, {r.r_nw, r.ram_a, r.ram_d});
      if (r.io_en)  chk("io_bus", {io_sel, io_dq}, {r.io_sel, r.io_d});
      if (r.gnt == '0) chk("idle_zero", {ram_r_nw, ram_a, ram_dq, io_sel, io_dq}, 64'd0);
    end
    if (rsp_q.size() != 0 && rsp_q[0].cyc == cyc) begin
      chk("rvalid", 64'(rvalid), 64'(NM'(1) << rsp_q[0].m));
      chk("rdata", 64'(rdata), 64'(rsp_q[0].d));
      void'(rsp_q.pop_front());
    end else begin
      chk("rvalid_idle", 64'(rvalid), 64'd0);
    end
    if (!rstn) chk("rst_rdata", 64'(rdata), 64'(ram_di));
  end

  function automatic bit eligible(int c);
    return mst[c].act && (!lock || c == int'(LM))
        && !(is_io(mst[c].a) && mst[c].wr && io_full);
  endfunction

  task automatic step();
    int   win;
    txn_t t;
    rec_t r;
    for (int m = 0; m < NM; m++) begin
      req[m] = mst[m].act;
      wr[m]  = mst[m].wr;
      addr[32*m +: 32] = mst[m].a;
      dout[8*m +: 8]   = mst[m].d;
    end
    win = -1;
    for (int k = 1; k <= NM; k++) begin
      int c;
`ifdef MEMBUS_ROUND_ROBIN_EN
      c = (mdl_last + k) % NM;
`else
      c = k - 1;
`endif
      if (win < 0 && eligible(c)) win = c;
    end
    r = '0;
    r.cyc = cyc;
    if (win >= 0) begin
      t = mst[win];
      r.gnt = NM'(1) << win;
      if (is_io(t.a)) begin
        r.io_en = 1'b1; r.io_wr = t.wr; r.io_sel = t.a[2:0]; r.io_d = t.d;
      end else begin
        r.ram_en = 1'b1; r.r_nw = !t.wr; r.ram_a = t.a[AW-1:0]; r.ram_d = t.d;
      end
      if (rstn) begin
        if (t.wr) begin
          if (is_io(t.a)) mdl_io[int'(t.a & 32'h7)] = t.d;
          else            mdl_ram[ram_key(t.a)] = t.d;
        end else begin
          rsp_q.push_back('{cyc: cyc + 1, m: win, d: mdl_rd(t.a)});
        end
        mdl_last = win;
        mst[win].act = 1'b0;
      end
    end
    rec_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic set_txn(int m, bit w, logic [31:0] a, logic [7:0] d);
    mst[m].act = 1'b1; mst[m].wr = w; mst[m].a = a; mst[m].d = d;
  endtask

  task automatic do_reset(int n);
    rstn = 1'b0;
    rsp_q.delete();
    for (int m = 0; m < NM; m++) mst[m].act = 1'b0;
    lock = 1'b0; io_full = 1'b0; mdl_last = NM - 1;
    repeat (n) step();
    rstn = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    logic [31:0] hi;
    hi = $urandom & 32'hFFFC_0000;
    t.act = 1'b1;
    t.wr  = 1'($urandom_range(0, 1));
    t.d   = 8'($urandom);
    case ($urandom_range(0, 2))
      0: t.a = hi | (32'($urandom_range(0, 1)) << 16) | 32'($urandom_range(0, 31));
      1: t.a = hi | 32'h2_0000 | 32'($urandom_range(0, 31));
      default: t.a = hi | 32'h3_0000 | ($urandom & 32'hFFF8) | 32'($urandom_range(0, 7));
    endcase
    return t;
  endfunction

  initial begin
    for (int m = 0; m < NM; m++) mst[m] = '{act: 1'b0, wr: 1'b0, a: 32'h0, d: 8'h0};
    @(posedge clk);
    #1;
    do_reset(3);

    // single RAM read
    dev_ram[32'h10] = 8'h5A; mdl_ram[32'h10] = 8'h5A;
    set_txn(0, 1'b0, 32'h0001_0010 & 32'h0000_0010, 8'h00);
    step(); step();

    // two masters contending continuously
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++)
        if (!mst[m].act) set_txn(m, 1'b0, 32'(8 * m + i), 8'h00);
      step();
    end
    for (int m = 0; m < NM; m++) mst[m].act = 1'b0;
    step();

    // I/O write stalled by full buffer
    io_full = 1'b1;
    set_txn(0, 1'b1, 32'h0003_0000, 8'h41);
    repeat (3) step();
    io_full = 1'b0;
    step(); step();

    // I/O read then RAM read: response mux follows the registered target
    dev_io[4] = 8'h37; mdl_io[4] = 8'h37;
    dev_ram[32'h20] = 8'h99; mdl_ram[32'h20] = 8'h99;
    set_txn(0, 1'b0, 32'h0003_0004, 8'h00); step();
    set_txn(0, 1'b0, 32'h0000_0020, 8'h00); step();
    step();

    // lock: read granted just before lock still answers
    set_txn(0, 1'b0, 32'h40, 8'h00); step();
    lock = 1'b1;
    set_txn(0, 1'b0, 32'h41, 8'h00);
    set_txn(1, 1'b0, 32'h42, 8'h00);
    repeat (3) step();
    lock = 1'b0;
    step(); step();

    // reset the cycle after a read grant
    set_txn(0, 1'b0, 32'h10, 8'h00); step();
    do_reset(2);
    for (int m = 0; m < NM; m++) set_txn(m, 1'b0, 32'(m + 1), 8'h00);
    step();
    for (int m = 0; m < NM; m++) mst[m].act = 1'b0;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < NM; m++)
        if (!mst[m].act && $urandom_range(0, 1) == 1) mst[m] = rand_txn();
      if ($urandom_range(0, 9) == 0) lock = !lock;
      io_full = ($urandom_range(0, 3) == 0);
      step();
    end

    lock = 1'b0; io_full = 1'b0;
    repeat (2 * NM + 2) step();
    chk("rsp_drain", 64'(rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised byte-wide memory-bus arbiter and address decoder that sits between N bus masters and the two shared targets: the 128 KiB RAM and the HCI I/O port. It replaces the fixed two-way CPU/HCI mux in the top level with these features:
- per-cycle arbitration, with round-robin or fixed priority
- a debug lock that hands the bus to one master exclusively
- write back-pressure from I/O buffer full
- a registered response path that returns read data one cycle later, tagged to the requesting master

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- RAM_ADDR_WIDTH, 17, RAM address width; address bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11 select I/O
- LOCK_MASTER, NUM_MASTERS-1, index granted exclusively while lock_in is high

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk_in  in  1  system clock
- rstn_in  in  1  asynchronous active-low reset
- lock_in  in  1  debug lock; only LOCK_MASTER may be granted
- m_req_in  in  NUM_MASTERS  per-master access request
- m_a_in  in  32*NUM_MASTERS  per-master byte address, flattened, master 0 in LSBs
- m_wr_in  in  NUM_MASTERS  1 = write, 0 = read
- m_dout_in  in  8*NUM_MASTERS  per-master write data
- m_gnt_out  out  NUM_MASTERS  one-hot grant for this cycle
- m_rvalid_out  out  NUM_MASTERS  one-hot read response strobe
- m_rdata_out  out  8  read data, shared by all masters
- ram_en_out  out  1  RAM enable
- ram_r_nw_out  out  1  1 = read, 0 = write
- ram_a_out  out  RAM_ADDR_WIDTH  RAM address
- ram_d_out  out  8  RAM write data
- ram_d_in  in  8  RAM read data, valid one cycle after the access
- io_en_out  out  1  I/O enable
- io_sel_out  out  3  I/O register select, address [2:0]
- io_wr_out  out  1  I/O write
- io_d_out  out  8  I/O write data
- io_d_in  in  8  I/O read data, valid one cycle after the access
- io_full_in  in  1  HCI output buffer full

## Operation
- Eligibility:
  - A master is eligible when its req is high and, if lock_in is high, its index is LOCK_MASTER.
  - A master is not eligible when it targets I/O with wr=1 while io_full_in is high; that write stalls and its gnt stays low.
- Arbitration:
  - Combinational, one grant per cycle at most.
  - Round-robin starts searching at index last_gnt+1 and wraps at NUM_MASTERS-1 back to 0.
  - last_gnt updates on every cycle that has a grant.
- Grant routing:
  - The winner's address, wr and data drive the targets in the same cycle.
  - The decode asserts exactly one of ram_en_out or io_en_out.
  - When there is no grant: ram_en_out=0, io_en_out=0, io_wr_out=0, and the remaining target outputs are don't-care, driven to 0.
- Response registers:
  - q_valid is set if the granted access is a read.
  - q_master records the winner index.
  - q_io records whether the target was I/O.
  - Next cycle: m_rvalid_out[q_master]=q_valid, and m_rdata_out = q_io ? io_d_in : ram_d_in.
- Writes produce no rvalid. The gnt pulse is the completion.
- A master must hold req, a, wr and dout stable until it sees gnt.
- lock_in asserted mid-stream:
  - An already-granted read still returns its rvalid the next cycle.
  - No new grants go to non-lock masters.
- On lock_in deassertion, arbitration resumes from the stored last_gnt.

## Timing
- Grant: combinational, same cycle as req. Target strobes: same cycle as gnt.
- Read latency: rvalid and rdata one cycle after gnt. A master may re-request in the cycle after gnt, so back-to-back reads give one response per cycle.
- Reset values:
  - m_rvalid_out = 0
  - q_valid = 0, q_io = 0, q_master = 0
  - last_gnt = NUM_MASTERS-1, so master 0 wins first
  - m_gnt_out, ram_en_out, io_en_out follow inputs combinationally
  - m_rdata_out = ram_d_in
- Reset asserted mid-operation: a pending response is dropped and rvalid falls immediately (asynchronous).
- io_full_in affects only I/O writes. I/O reads and RAM accesses proceed normally.

## Configuration
- MEMBUS_ROUND_ROBIN_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, lowest index wins. last_gnt is not implemented, and lock behaviour is unchanged.

## Structure
- Package membus_pkg holds:
  - the I/O region decode constant 2'b11 and its bit positions, as functions of RAM_ADDR_WIDTH
  - the I/O select width, 3
  - the one-hot-to-index function used for q_master
- Sub-module rr_arbiter(N): eligibility vector in, one-hot grant and updated pointer out. Instantiated once.

## Test plan
- Reset, then master 0 reads RAM 0x00010, ram_d_in=0x5A: gnt[0] in cycle 1, rvalid[0] with rdata=0x5A in cycle 2.
- Masters 0 and 1 both request continuously for 4 cycles: grants alternate 0,1,0,1. With MEMBUS_ROUND_ROBIN_EN undefined: 0,0,0,0.
- Master 0 writes 0x41 to 0x30000 with io_full_in=1 for 3 cycles: gnt stays low and io_en=0. When full drops, io_en=1, io_wr=1, io_d=0x41 and io_sel=0.
- Read from 0x30004 with io_d_in=0x37, followed by a RAM read with ram_d_in=0x99: rdata 0x37, then 0x99. The response mux follows the registered target.
- lock_in=1 with both masters requesting: only master 1 is granted. A master-0 read granted the cycle before lock still receives its rvalid.
- Reset asserted the cycle after a read grant: rvalid stays 0, and the first grant after release goes to master 0.
